iot_collect: RTL

- Front-end collector for the IoT data-filtering core.
- Accepts one 8-bit sample byte per cycle on iot_in, MSB-first, and assembles each run of 16 bytes into one 128-bit word.
- Emits the assembled word, the position counters cnt_cycle/cnt_data and a one-cycle word strobe to the filter function units (max/min/average/extract/...).
- Producer end of the data/cnt_cycle/cnt_data interface those units consume. Also drives busy back-pressure to the byte source.

---
 rtl/iotdf_pkg.sv | 16 +
 rtl/iot_byte_shifter.sv | 35 +++
 rtl/iot_collect.sv | 81 ++++++++
 3 files changed

// File: rtl/iotdf_pkg.sv
// Shared constants and types for the IoT data-filtering core.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package iotdf_pkg;

  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_WORD  = 16;
  localparam int WORDS_PER_ROUND = 8;
  localparam int WORD_W          = BYTE_W * BYTES_PER_WORD;

  localparam int CYC_W = 4;
  localparam int DAT_W = 3;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/iot_byte_shifter.sv
// MSB-first byte shift register; latches the full word when its last byte arrives.
// Latency: completed word appears on data one edge after the final byte is accepted.
// Backpressure: none internally; accept gates every state change.
module iot_byte_shifter
  import iotdf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              last,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] data,
  output logic              done
);

  word_t shift_reg;
  word_t next_word;

  // The new byte enters at the LSB, so the first byte of a word ends up as its MSB.
  assign next_word = {shift_reg[WORD_W-BYTE_W-1:0], din};
  assign done      = accept & last;

  // Shift on every accepted byte; publish the word only when it is complete so
  // consumers see a stable value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      data      <= '0;
    end else begin
      if (accept) shift_reg <= next_word;
      if (done)   data      <= next_word;
    end
  end

endmodule

// File: rtl/iot_collect.sv
// Collects 16 sample bytes per word and strobes each finished word to the filter units.
// Latency: data/word_valid/round_done valid one edge after the 16th byte is accepted.
// Backpressure: busy is hold registered once; bytes offered while busy=1 are dropped.
// Optional: define IOT_ROUND_CNT_EN to add the 8-bit round_id output.
module iot_collect
  import iotdf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [BYTE_W-1:0] iot_in,
  input  logic              hold,
  output logic              busy,
  output logic [WORD_W-1:0] data,
  output logic [CYC_W-1:0]  cnt_cycle,
  output logic [DAT_W-1:0]  cnt_data,
  output logic              word_valid,
  output logic              round_done
`ifdef IOT_ROUND_CNT_EN
  ,
  output logic [7:0]        round_id
`endif
);

  logic accept;
  logic last_byte;
  logic last_word;
  logic word_done;

  // busy is registered, so a byte offered in the cycle hold first rises still gets in.
  assign accept    = in_en & ~busy;
  assign last_byte = (cnt_cycle == CYC_W'(BYTES_PER_WORD - 1));
  assign last_word = (cnt_data == DAT_W'(WORDS_PER_ROUND - 1));

  iot_byte_shifter u_shifter (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .last   (last_byte),
    .din    (iot_in),
    .data   (data),
    .done   (word_done)
  );

  // One-cycle registered copy of the downstream stall request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= hold;
  end

  // Byte and word position counters; both only move on an accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_cycle <= '0;
      cnt_data  <= '0;
    end else if (accept) begin
      cnt_cycle <= last_byte ? '0 : cnt_cycle + CYC_W'(1);
      if (last_byte) cnt_data <= last_word ? '0 : cnt_data + DAT_W'(1);
    end
  end

  // Strobes are single-cycle and coincide with the newly published word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_valid <= 1'b0;
      round_done <= 1'b0;
    end else begin
      word_valid <= word_done;
      round_done <= word_done & last_word;
    end
  end

`ifdef IOT_ROUND_CNT_EN
  // Round counter advances on the same edge that raises round_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        round_id <= '0;
    else if (word_done & last_word) round_id <= round_id + 8'd1;
  end
`endif

endmodule
